// File: rtl/cache_mem_pkg.sv
// Shared types and width helpers for the line-fill responder and its storage.
// Defaults describe a 256-word array organised as 64 lines of 4 words.
package cache_mem_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_ADDR_WIDTH   = 8;
    localparam int DEF_LINE_WORDS   = 4;
    localparam int DEF_READ_LATENCY = 2;

    localparam int DEF_OFF_WIDTH  = $clog2(DEF_LINE_WORDS);
    localparam int DEF_LINE_WIDTH = DEF_ADDR_WIDTH - DEF_OFF_WIDTH;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_BURST = 2'd2,
        WR_BURST = 2'd3
    } state_t;

    // Word-offset bits within a line.
    function automatic int off_width(input int line_words);
        return $clog2(line_words);
    endfunction

    // Line-address bits; line and offset together span the full word address.
    function automatic int line_width(input int addr_width, input int line_words);
        return addr_width - $clog2(line_words);
    endfunction

endpackage

// File: rtl/line_fill_responder_if.sv
// Request / writeback / fill bus between a cache controller (master) and the
// line-fill responder (slave).
interface line_fill_responder_if
    import cache_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) ();

    localparam int OFF_W  = off_width(LINE_WORDS);
    localparam int LINE_W = line_width(ADDR_WIDTH, LINE_WORDS);

    // Every channel uses the same rule: a transfer happens on a rising clk edge
    // where valid && ready; valid never waits for ready, and the producer holds
    // its payload stable while valid is high and ready is low.
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [LINE_W-1:0]     req_line;
    logic [OFF_W-1:0]      req_word;

    logic                  wdata_valid;
    logic                  wdata_ready;
    logic [DATA_WIDTH-1:0] wdata;

    logic                  rdata_valid;
    logic                  rdata_ready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_last;

    logic                  busy;
    state_t                state;

    modport master (
        output req_valid, req_write, req_line, req_word,
        output wdata_valid, wdata,
        output rdata_ready,
        input  req_ready, wdata_ready,
        input  rdata_valid, rdata, rdata_last,
        input  busy, state
    );

    modport slave (
        input  req_valid, req_write, req_line, req_word,
        input  wdata_valid, wdata,
        input  rdata_ready,
        output req_ready, wdata_ready,
        output rdata_valid, rdata, rdata_last,
        output busy, state
    );

endinterface

// File: rtl/line_mem_array.sv
// Single-port word array: synchronous write, asynchronous read at the same address.
// Contents are never reset.
module line_mem_array #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/line_fill_responder.sv
// Serves whole-line fills (critical word first, fixed read latency) and line
// writebacks against a local word array, one line transfer at a time.
module line_fill_responder
    import cache_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int LINE_WORDS   = DEF_LINE_WORDS,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input logic                   clk,
    input logic                   reset,
    line_fill_responder_if.slave  bus
);

    localparam int OFF_W  = off_width(LINE_WORDS);
    localparam int LINE_W = line_width(ADDR_WIDTH, LINE_WORDS);

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
    localparam logic [OFF_W-1:0] ONE_BEAT  = OFF_W'(1);
    localparam logic [3:0]       WAIT_INIT = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;

    state_t              r_state;
    logic [LINE_W-1:0]   r_line;
    logic [OFF_W-1:0]    r_word;
    logic [OFF_W-1:0]    r_beat;
    logic [3:0]          r_wait;

    state_t              w_state_nxt;
    logic [LINE_W-1:0]   w_line_nxt;
    logic [OFF_W-1:0]    w_word_nxt;
    logic [OFF_W-1:0]    w_beat_nxt;
    logic [3:0]          w_wait_nxt;

    logic                w_req_ready;
    logic                w_wdata_ready;
    logic                w_rdata_valid;
    logic                w_rdata_last;
    logic                w_we;
    logic [OFF_W-1:0]    w_offset;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    // Offset wraps inside the line, which gives critical-word-first order for free.
    assign w_offset = r_word + r_beat;
    assign w_addr   = {r_line, w_offset};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_line  <= '0;
            r_word  <= '0;
            r_beat  <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_line  <= w_line_nxt;
            r_word  <= w_word_nxt;
            r_beat  <= w_beat_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_line_nxt    = r_line;
        w_word_nxt    = r_word;
        w_beat_nxt    = r_beat;
        w_wait_nxt    = r_wait;
        w_req_ready   = 1'b0;
        w_wdata_ready = 1'b0;
        w_rdata_valid = 1'b0;
        w_rdata_last  = 1'b0;
        w_we          = 1'b0;

        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_line_nxt = bus.req_line;
                    w_word_nxt = bus.req_word;
                    w_beat_nxt = '0;
                    if (bus.req_write) begin
                        w_state_nxt = WR_BURST;
                    end else if (READ_LATENCY > 0) begin
                        w_state_nxt = RD_WAIT;
                        w_wait_nxt  = WAIT_INIT;
                    end else begin
                        w_state_nxt = RD_BURST;
                    end
                end
            end

            RD_WAIT: begin
                if (r_wait == 4'd0) begin
                    w_state_nxt = RD_BURST;
                end else begin
                    w_wait_nxt = r_wait - 4'd1;
                end
            end

            RD_BURST: begin
                w_rdata_valid = 1'b1;
                w_rdata_last  = (r_beat == LAST_BEAT);
                if (bus.rdata_ready) begin
                    w_beat_nxt = r_beat + ONE_BEAT;
                    if (r_beat == LAST_BEAT) begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            WR_BURST: begin
                w_wdata_ready = 1'b1;
                if (bus.wdata_valid) begin
                    w_we       = 1'b1;
                    w_beat_nxt = r_beat + ONE_BEAT;
                    if (r_beat == LAST_BEAT) begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    line_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (bus.wdata),
        .o_rdata (w_mem_rdata)
    );

    assign bus.req_ready   = w_req_ready;
    assign bus.wdata_ready = w_wdata_ready;
    assign bus.rdata_valid = w_rdata_valid;
    assign bus.rdata_last  = w_rdata_last;
    // Fill data is gated so the bus reads zero whenever no beat is offered.
    assign bus.rdata       = w_rdata_valid ? w_mem_rdata : '0;
    assign bus.busy        = (r_state != IDLE);
    assign bus.state       = r_state;

    a_ready_only_idle: assert property (@(posedge clk) disable iff (reset)
        bus.req_ready |-> !bus.busy);

    a_one_data_channel: assert property (@(posedge clk) disable iff (reset)
        !(bus.rdata_valid && bus.wdata_ready));

    a_fill_held_under_stall: assert property (@(posedge clk) disable iff (reset)
        (bus.rdata_valid && !bus.rdata_ready) |=> (bus.rdata_valid && $stable(bus.rdata_last)));

endmodule

// File: tb/tb_line_fill_responder.sv
// Directed bench for line_fill_responder: one instance at read latency 2, one at 0.
// Fill beats are predicted into per-instance queues and checked by a negedge monitor.
module tb_line_fill_responder;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int LW  = 4;
    localparam int RL  = 2;
    localparam int OW  = $clog2(LW);
    localparam int LNW = AW - OW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst           [2];
    logic           d_req_valid   [2];
    logic           d_req_write   [2];
    logic [LNW-1:0] d_req_line    [2];
    logic [OW-1:0]  d_req_word    [2];
    logic           d_wdata_valid [2];
    logic [DW-1:0]  d_wdata       [2];
    logic           d_rdata_ready [2];

    logic           s_req_ready   [2];
    logic           s_wdata_ready [2];
    logic           s_rdata_valid [2];
    logic [DW-1:0]  s_rdata       [2];
    logic           s_rdata_last  [2];
    logic           s_busy        [2];

    line_fill_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WORDS(LW)) bus_a ();
    line_fill_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WORDS(LW)) bus_b ();

    line_fill_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WORDS(LW), .READ_LATENCY(RL)) dut_a (
        .clk   (clk),
        .reset (rst[0]),
        .bus   (bus_a)
    );

    line_fill_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WORDS(LW), .READ_LATENCY(0)) dut_b (
        .clk   (clk),
        .reset (rst[1]),
        .bus   (bus_b)
    );

    assign bus_a.req_valid   = d_req_valid[0];
    assign bus_a.req_write   = d_req_write[0];
    assign bus_a.req_line    = d_req_line[0];
    assign bus_a.req_word    = d_req_word[0];
    assign bus_a.wdata_valid = d_wdata_valid[0];
    assign bus_a.wdata       = d_wdata[0];
    assign bus_a.rdata_ready = d_rdata_ready[0];
    assign s_req_ready[0]    = bus_a.req_ready;
    assign s_wdata_ready[0]  = bus_a.wdata_ready;
    assign s_rdata_valid[0]  = bus_a.rdata_valid;
    assign s_rdata[0]        = bus_a.rdata;
    assign s_rdata_last[0]   = bus_a.rdata_last;
    assign s_busy[0]         = bus_a.busy;

    assign bus_b.req_valid   = d_req_valid[1];
    assign bus_b.req_write   = d_req_write[1];
    assign bus_b.req_line    = d_req_line[1];
    assign bus_b.req_word    = d_req_word[1];
    assign bus_b.wdata_valid = d_wdata_valid[1];
    assign bus_b.wdata       = d_wdata[1];
    assign bus_b.rdata_ready = d_rdata_ready[1];
    assign s_req_ready[1]    = bus_b.req_ready;
    assign s_wdata_ready[1]  = bus_b.wdata_ready;
    assign s_rdata_valid[1]  = bus_b.rdata_valid;
    assign s_rdata[1]        = bus_b.rdata;
    assign s_rdata_last[1]   = bus_b.rdata_last;
    assign s_busy[1]         = bus_b.busy;

    int total = 0;
    int bad   = 0;

    logic [DW:0] exp0_q[$];
    logic [DW:0] exp1_q[$];
    logic [DW:0] held   [2];
    logic        held_v [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat_of(input int u);
        return (u == 0) ? RL : 0;
    endfunction

    // ---------------- scoreboard monitor ----------------
    task automatic mon_unit(input int u);
        logic [DW:0] got;
        logic [DW:0] want;
        logic        empty;
        if (rst[u]) begin
            held_v[u] = 1'b0;
        end else begin
            got = {s_rdata_last[u], s_rdata[u]};
            if (held_v[u]) begin
                check("valid_held", 32'(s_rdata_valid[u]), 32'd1);
                check("beat_stable", 32'(got), 32'(held[u]));
            end
            if (s_rdata_valid[u] && d_rdata_ready[u]) begin
                empty = (u == 0) ? (exp0_q.size() == 0) : (exp1_q.size() == 0);
                if (empty) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat u%0d: got=%0h want=none", u, got);
                end else begin
                    if (u == 0) want = exp0_q.pop_front();
                    else        want = exp1_q.pop_front();
                    check("beat", 32'(got), 32'(want));
                end
            end
            if (!s_rdata_valid[u] && s_rdata_last[u]) begin
                check("last_without_valid", 32'(s_rdata_last[u]), 32'd0);
            end
            held_v[u] = s_rdata_valid[u] && !d_rdata_ready[u];
            held[u]   = got;
        end
    endtask

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) mon_unit(u);
    end

    // ---------------- driver tasks ----------------
    task automatic wait_req_ready(input int u, output int waits);
        waits = 0;
        while (!s_req_ready[u] && waits < 50) begin
            step();
            waits++;
        end
        if (waits >= 50) check("req_ready_timeout", 32'(s_req_ready[u]), 32'd1);
    endtask

    task automatic do_write(input int u, input logic [LNW-1:0] line, input logic [OW-1:0] word,
                            input logic [LW*DW-1:0] data, input int nbeats, input int gap_beat);
        int waits;
        wait_req_ready(u, waits);
        d_req_valid[u] = 1'b1;
        d_req_write[u] = 1'b1;
        d_req_line[u]  = line;
        d_req_word[u]  = word;
        step();
        d_req_valid[u] = 1'b0;
        check("wr_busy", 32'(s_busy[u]), 32'd1);
        for (int k = 0; k < nbeats; k++) begin
            if (k == gap_beat) begin
                d_wdata_valid[u] = 1'b0;
                step();
            end
            d_wdata_valid[u] = 1'b1;
            d_wdata[u]       = data[(LW-1-k)*DW +: DW];
            check("wdata_ready", 32'(s_wdata_ready[u]), 32'd1);
            step();
        end
        d_wdata_valid[u] = 1'b0;
        if (nbeats == LW) check("wr_done_idle", 32'(s_req_ready[u]), 32'd1);
    endtask

    task automatic do_read(input int u, input logic [LNW-1:0] line, input logic [OW-1:0] word,
                           input logic [LW*DW-1:0] expw, input int stall_beat, input int stall_cycles,
                           input bit hold_next, input logic [LNW-1:0] nline, input logic [OW-1:0] nword,
                           input bit immediate);
        int   waits;
        int   cyc;
        int   first;
        int   last_take;
        int   k;
        int   g;
        int   left;
        logic v;
        logic take;
        wait_req_ready(u, waits);
        if (immediate) check("accept_wait", 32'(waits), 32'd0);
        for (int i = 0; i < LW; i++) begin
            if (u == 0) exp0_q.push_back({(i == LW-1), expw[(LW-1-i)*DW +: DW]});
            else        exp1_q.push_back({(i == LW-1), expw[(LW-1-i)*DW +: DW]});
        end
        d_req_valid[u] = 1'b1;
        d_req_write[u] = 1'b0;
        d_req_line[u]  = line;
        d_req_word[u]  = word;
        step();
        if (hold_next) begin
            d_req_line[u] = nline;
            d_req_word[u] = nword;
        end else begin
            d_req_valid[u] = 1'b0;
        end
        check("rd_busy", 32'(s_busy[u]), 32'd1);
        cyc = 1; first = -1; last_take = -1; k = 0; g = 0; left = stall_cycles;
        while (k < LW && g < 100) begin
            v = s_rdata_valid[u];
            if (v && first < 0) first = cyc;
            if (hold_next) check("req_ready_busy", 32'(s_req_ready[u]), 32'd0);
            if (v && k == stall_beat && left > 0) begin
                d_rdata_ready[u] = 1'b0;
                left--;
            end else begin
                d_rdata_ready[u] = 1'b1;
            end
            take = v && d_rdata_ready[u];
            if (take) begin
                k++;
                last_take = cyc;
            end
            step();
            cyc++;
            g++;
        end
        d_rdata_ready[u] = 1'b1;
        check("beats_taken", 32'(k), 32'(LW));
        check("first_latency", 32'(first), 32'(lat_of(u) + 1));
        check("burst_span", 32'(last_take - first), 32'(LW - 1 + stall_cycles));
        check("idle_after_fill", 32'(s_req_ready[u]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u]           = 1'b1;
            d_req_valid[u]   = 1'b0;
            d_req_write[u]   = 1'b0;
            d_req_line[u]    = '0;
            d_req_word[u]    = '0;
            d_wdata_valid[u] = 1'b0;
            d_wdata[u]       = '0;
            d_rdata_ready[u] = 1'b1;
            held[u]          = '0;
            held_v[u]        = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",        32'(s_busy[0]),        32'd0);
        check("rst_req_ready",   32'(s_req_ready[0]),   32'd1);
        check("rst_rdata_valid", 32'(s_rdata_valid[0]), 32'd0);
        check("rst_rdata_last",  32'(s_rdata_last[0]),  32'd0);
        check("rst_wdata_ready", 32'(s_wdata_ready[0]), 32'd0);
        check("rst_rdata",       32'(s_rdata[0]),       32'd0);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        step();
        check("rel_req_ready", 32'(s_req_ready[1]), 32'd1);
        check("rel_busy",      32'(s_busy[1]),      32'd0);

        // Preload line 5 with 0x10..0x13, then hold wdata_valid in IDLE; it must be ignored.
        do_write(0, 6'h05, 2'd0, 32'h10111213, LW, -1);
        d_wdata_valid[0] = 1'b1;
        d_wdata[0]       = 8'hEE;
        check("idle_wdata_ready", 32'(s_wdata_ready[0]), 32'd0);
        step();
        step();
        d_wdata_valid[0] = 1'b0;

        do_read(0, 6'h05, 2'd0, 32'h10111213, -1, 0, 1'b0, '0, '0, 1'b0);
        do_read(0, 6'h05, 2'd2, 32'h12131011, -1, 0, 1'b0, '0, '0, 1'b0);
        do_read(0, 6'h05, 2'd0, 32'h10111213, 1, 3, 1'b0, '0, '0, 1'b0);

        // Writeback starting at offset 1 with a one-cycle gap before beat 2.
        do_write(0, 6'h3F, 2'd1, 32'hA1A2A3A4, LW, 2);
        do_read(0, 6'h3F, 2'd0, 32'hA4A1A2A3, -1, 0, 1'b0, '0, '0, 1'b0);

        // Next request held pending through a whole fill.
        do_read(0, 6'h05, 2'd1, 32'h11121310, -1, 0, 1'b1, 6'h3F, 2'd3, 1'b0);
        do_read(0, 6'h3F, 2'd3, 32'hA3A4A1A2, -1, 0, 1'b0, '0, '0, 1'b1);

        // Zero-latency instance: reset in the middle of a writeback.
        do_write(1, 6'h02, 2'd0, 32'h50515253, LW, -1);
        do_write(1, 6'h02, 2'd1, 32'h6061EEEE, 2, -1);
        #2;
        rst[1] = 1'b1;
        #1;
        check("midrst_busy",        32'(s_busy[1]),        32'd0);
        check("midrst_wdata_ready", 32'(s_wdata_ready[1]), 32'd0);
        check("midrst_rdata_valid", 32'(s_rdata_valid[1]), 32'd0);
        step();
        rst[1] = 1'b0;
        #1;
        check("postrst_busy",      32'(s_busy[1]),      32'd0);
        check("postrst_req_ready", 32'(s_req_ready[1]), 32'd1);
        step();
        do_read(1, 6'h02, 2'd0, 32'h50606153, -1, 0, 1'b0, '0, '0, 1'b0);

        step();
        step();
        check("q0_drained", 32'(exp0_q.size()), 32'd0);
        check("q1_drained", 32'(exp1_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_fill_responder.md
LINE_FILL_RESPONDER -- requirements
Module: line_fill_responder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8: width of one memory word.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8: word-address width; the array holds 2^ADDR_WIDTH words.
REQ-003 The block SHALL have parameter LINE_WORDS, default 4, power of two >= 2: words per cache line.
REQ-004 The block SHALL have parameter READ_LATENCY, default 2, range 0..15: idle cycles between read acceptance and the first data beat.
REQ-005 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  clock; reset is asynchronous, active-high, and named reset.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  line request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1 = line writeback, 0 = line fill.
- req_line  in  ADDR_WIDTH-log2(LINE_WORDS)  line address.
- req_word  in  log2(LINE_WORDS)  first word offset, for critical-word-first order.
- wdata_valid  in  1  writeback beat present.
- wdata_ready  out  1  writeback beat accepted.
- wdata  in  DATA_WIDTH  writeback beat data.
- rdata_valid  out  1  fill beat present.
- rdata_ready  in  1  requester accepts the fill beat.
- rdata  out  DATA_WIDTH  fill beat data.
- rdata_last  out  1  final beat of the line.
- busy  out  1  high in every state except IDLE.

Function
REQ-006 The FSM SHALL have states IDLE, RD_WAIT, RD_BURST and WR_BURST.
REQ-007 req_ready SHALL be 1 only in IDLE. A transfer is accepted at an edge where req_valid&&req_ready; req_line, req_word and req_write SHALL be latched at that edge.
REQ-008 On a read accept, the FSM SHALL go to RD_WAIT if READ_LATENCY>0 and stay there exactly READ_LATENCY cycles. If READ_LATENCY==0 it SHALL go directly to RD_BURST.
REQ-009 rdata_valid SHALL first be high READ_LATENCY+1 cycles after the accept edge.
REQ-010 In RD_BURST, beat k (k=0..LINE_WORDS-1) SHALL carry mem[{line, (req_word+k) mod LINE_WORDS}]. The offset wraps to 0 after LINE_WORDS-1.
REQ-011 A beat SHALL advance only on an edge with rdata_valid&&rdata_ready. While rdata_ready=0, rdata and rdata_last SHALL hold stable and rdata_valid SHALL stay high.
REQ-012 rdata_last SHALL be high only on beat LINE_WORDS-1. After that beat is taken, the FSM SHALL go to IDLE, with req_ready=1 in the next cycle.
REQ-013 On a write accept, the FSM SHALL go to WR_BURST, where wdata_ready=1. Each edge with wdata_valid&&wdata_ready SHALL write wdata to mem[{line, (req_word+k) mod LINE_WORDS}].
REQ-014 After LINE_WORDS write beats, the FSM SHALL go to IDLE.
REQ-015 Outside WR_BURST, wdata_ready SHALL be 0 and wdata_valid SHALL be ignored.
REQ-016 Outside RD_BURST, rdata_valid and rdata_last SHALL be 0.
REQ-017 A read of a line accepted after a writeback of that line completes SHALL return the written data, with no stale beats.
REQ-018 Offset and beat counters SHALL be log2(LINE_WORDS) bits wide and wrap modulo LINE_WORDS. Address concatenation SHALL be exactly ADDR_WIDTH bits.

Reset
REQ-019 Asserting reset SHALL force: state IDLE, busy=0, req_ready=1 after release, rdata_valid=0, rdata_last=0, wdata_ready=0, rdata=0, counters 0.
REQ-020 Reset mid-burst SHALL abort the transfer with no further beats. Write beats already taken SHALL remain in memory.
REQ-021 Reset SHALL NOT clear the memory array. Array contents are undefined at power-up.

Structure
REQ-022 Package cache_mem_pkg SHALL hold the state enum, default DATA_WIDTH/ADDR_WIDTH/LINE_WORDS, and the line/offset address-width helper constants.
REQ-023 The storage SHALL be a sub-module line_mem_array: single-port, synchronous write, read address driven by the FSM.

Verification
REQ-024 Fill, L=2: preload line 5 words = 0x10..0x13, req_word=0, rdata_ready=1 -> 0x10,0x11,0x12,0x13 on consecutive cycles starting 3 cycles after accept; rdata_last on 0x13.
REQ-025 Critical-word-first wrap: same line, req_word=2 -> 0x12,0x13,0x10,0x11; rdata_last on 0x11.
REQ-026 Backpressure: drop rdata_ready for 3 cycles at beat 1 -> beat 1 data held stable, no beat lost or duplicated, 4 beats total.
REQ-027 Writeback then fill: write line 0x3F, req_word=1, beats 0xA1..0xA4 -> a fill of line 0x3F with req_word=0 returns 0xA4,0xA1,0xA2,0xA3.
REQ-028 Reset mid-write after 2 beats with L=0 -> busy=0 and req_ready=1 after release; a fill then shows the 2 written words and the 2 words untouched.
REQ-029 Request during busy: req_valid held high in RD_BURST -> req_ready stays 0; the request is accepted on the first cycle after rdata_last is taken.
